dct_coef_sequencer: RTL and testbench

//  Computes one 2-D DCT-II coefficient F(k1,k2) of an 8x8 pixel block by walking all 64 (n1,n2) indices.
//  It drives the block-buffer read port and the cosine LUT bank select/index, then multiply-accumulates pixel*cos.
//  It scales and rounds the sum and returns the coefficient over a valid/ready handshake.

---
 rtl/dct_coef_sequencer.sv | 169 ++++++++++++++++
 tb/tb_dct_coef_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dct_coef_sequencer.sv
// Sequences one 2-D DCT-II coefficient F(k1,k2) over an 8x8 block: walks the 64 pixel/cos pairs,
// multiply-accumulates them, applies the DC normalisation and rounding, then offers the result on valid/ready.
module dct_coef_sequencer #(
    parameter int PIX_W  = 8,
    parameter int ACC_W  = 48,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 26
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [2:0]               k1,
    input  logic [2:0]               k2,
    output logic                     busy,
    output logic                     pix_re,
    output logic [5:0]               pix_addr,
    input  logic signed [PIX_W-1:0]  pix_rdata,
    output logic [2:0]               lut_k1,
    output logic [2:0]               lut_k2,
    output logic [2:0]               lut_n1,
    output logic [2:0]               lut_n2,
    input  logic signed [31:0]       lut_cos,
    output logic signed [COEF_W-1:0] coef,
    output logic                     coef_valid,
    input  logic                     coef_ready
);

    localparam int PROD_W = PIX_W + 32;
    localparam int TW     = ACC_W + 17;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_SCALE, S_DONE} state_t;

    state_t                     state_q;
    logic                       busy_q, pix_re_q, coef_valid_q, drain_q;
    logic [5:0]                 addr_q;
    logic [2:0]                 k1_q, k2_q;
    logic signed [COEF_W-1:0]   coef_q, coef_d;
    logic signed [31:0]         cos_p1;
    logic                       vld_p1, vld_p2;
    logic signed [PROD_W-1:0]   prod_p2, prod_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       accept;

    // acc * s1 * s2 with s = 181 (~256/sqrt2) for a zero frequency, 256 otherwise, then round half up
    function automatic logic signed [TW-1:0] scale_round(input logic signed [ACC_W-1:0] acc,
                                                         input logic [2:0] ka,
                                                         input logic [2:0] kb);
        logic [8:0]           s1, s2;
        logic [17:0]          s12;
        logic signed [TW-1:0] t, rnd;
        s1  = (ka == 3'd0) ? 9'd181 : 9'd256;
        s2  = (kb == 3'd0) ? 9'd181 : 9'd256;
        s12 = 18'(s1) * 18'(s2);
        t   = $signed({{17{acc[ACC_W-1]}}, acc}) * $signed({{(TW-18){1'b0}}, s12});
        rnd = '0;
        rnd[SHIFT-1] = 1'b1;
        return (t + rnd) >>> SHIFT;
    endfunction

    function automatic logic signed [COEF_W-1:0] saturate(input logic signed [TW-1:0] r);
        logic signed [TW-1:0] hi, lo;
        hi = '0;
        hi[COEF_W-2:0] = '1;
        lo = -hi - 1;
        if (r > hi)
            return {1'b0, {(COEF_W-1){1'b1}}};
        else if (r < lo)
            return {1'b1, {(COEF_W-1){1'b0}}};
        else
            return r[COEF_W-1:0];
    endfunction

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        prod_d = $signed({{32{pix_rdata[PIX_W-1]}}, pix_rdata}) * $signed({{PIX_W{cos_p1[31]}}, cos_p1});
        acc_d  = acc_q + $signed({{(ACC_W-PROD_W){prod_p2[PROD_W-1]}}, prod_p2});
        coef_d = saturate(scale_round(acc_q, k1_q, k2_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            pix_re_q     <= 1'b0;
            addr_q       <= '0;
            drain_q      <= 1'b0;
            k1_q         <= '0;
            k2_q         <= '0;
            coef_q       <= '0;
            coef_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q  <= S_RUN;
                        busy_q   <= 1'b1;
                        pix_re_q <= 1'b1;
                        addr_q   <= '0;
                        k1_q     <= k1;
                        k2_q     <= k2;
                    end
                end
                S_RUN: begin
                    if (addr_q == 6'd63) begin
                        state_q  <= S_DRAIN;
                        pix_re_q <= 1'b0;
                        addr_q   <= '0;
                        drain_q  <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 6'd1;
                    end
                end
                // two cycles let the last read pass through the product and accumulate stages
                S_DRAIN: begin
                    if (drain_q)
                        state_q <= S_SCALE;
                    else
                        drain_q <= 1'b1;
                end
                S_SCALE: begin
                    coef_q       <= coef_d;
                    coef_valid_q <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE: begin
                    if (coef_ready) begin
                        coef_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_p1  <= '0;
            vld_p1  <= 1'b0;
            prod_p2 <= '0;
            vld_p2  <= 1'b0;
            acc_q   <= '0;
        end else begin
            // p1: cos captured so it lines up with the pixel returned one cycle after its address
            cos_p1 <= lut_cos;
            vld_p1 <= pix_re_q;
            // p2: product of the aligned pair
            prod_p2 <= prod_d;
            vld_p2  <= vld_p1;
            if (accept)
                acc_q <= '0;
            else if (vld_p2)
                acc_q <= acc_d;
        end
    end

    assign busy       = busy_q;
    assign pix_re     = pix_re_q;
    assign pix_addr   = addr_q;
    assign lut_k1     = k1_q;
    assign lut_k2     = k2_q;
    assign lut_n1     = addr_q[5:3];
    assign lut_n2     = addr_q[2:0];
    assign coef       = coef_q;
    assign coef_valid = coef_valid_q;

endmodule

// File: tb/tb_dct_coef_sequencer.sv
// Directed bench for dct_coef_sequencer: a 16-bit and an 8-bit instance share stimulus; a monitor
// scoreboards every accepted coefficient against hand-computed expectations.
module tb_dct_coef_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, coef_ready;
    logic [2:0]  k1, k2;

    logic              busy_a, pix_re_a, coef_valid_a;
    logic [5:0]        pix_addr_a;
    logic [2:0]        lut_k1_a, lut_k2_a, lut_n1_a, lut_n2_a;
    logic signed [7:0] rdata_a;
    logic signed [31:0] cos_a;
    logic signed [15:0] coef_a;

    logic              busy_b, pix_re_b, coef_valid_b;
    logic [5:0]        pix_addr_b;
    logic [2:0]        lut_k1_b, lut_k2_b, lut_n1_b, lut_n2_b;
    logic signed [7:0] rdata_b;
    logic signed [31:0] cos_b;
    logic signed [7:0] coef_b;

    logic signed [7:0]  mem [64];
    logic signed [31:0] lut_tab [64];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int exp_a[$];
    int exp_b[$];

    dct_coef_sequencer #(.PIX_W(8), .ACC_W(48), .COEF_W(16), .SHIFT(26)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .k1(k1), .k2(k2),
        .busy(busy_a), .pix_re(pix_re_a), .pix_addr(pix_addr_a), .pix_rdata(rdata_a),
        .lut_k1(lut_k1_a), .lut_k2(lut_k2_a), .lut_n1(lut_n1_a), .lut_n2(lut_n2_a),
        .lut_cos(cos_a), .coef(coef_a), .coef_valid(coef_valid_a), .coef_ready(coef_ready)
    );

    dct_coef_sequencer #(.PIX_W(8), .ACC_W(48), .COEF_W(8), .SHIFT(26)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .k1(k1), .k2(k2),
        .busy(busy_b), .pix_re(pix_re_b), .pix_addr(pix_addr_b), .pix_rdata(rdata_b),
        .lut_k1(lut_k1_b), .lut_k2(lut_k2_b), .lut_n1(lut_n1_b), .lut_n2(lut_n2_b),
        .lut_cos(cos_b), .coef(coef_b), .coef_valid(coef_valid_b), .coef_ready(coef_ready)
    );

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rdata_a <= mem[pix_addr_a];
        rdata_b <= mem[pix_addr_b];
    end
    assign cos_a = lut_tab[{lut_n1_a, lut_n2_a}];
    assign cos_b = lut_tab[{lut_n1_b, lut_n2_b}];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // scoreboard monitor: pops on every handshake
    always @(negedge clk) begin
        if (rst_n && coef_ready && coef_valid_a) begin
            if (exp_a.size() == 0) begin
                checks++; errors++;
                $display("FAIL coef_a_unexpected: got %0d, expected no result", coef_a);
            end else begin
                chk("coef_a", coef_a, exp_a.pop_front());
            end
        end
        if (rst_n && coef_ready && coef_valid_b) begin
            if (exp_b.size() == 0) begin
                checks++; errors++;
                $display("FAIL coef_b_unexpected: got %0d, expected no result", coef_b);
            end else begin
                chk("coef_b", coef_b, exp_b.pop_front());
            end
        end
    end

    task automatic fill_const(input int pix, input int cosv);
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 8'(pix);
            lut_tab[i] = cosv;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_pix_re"}, pix_re_a, 0);
        chk({tag, "_pix_addr"}, pix_addr_a, 0);
        chk({tag, "_lut_k"}, {lut_k1_a, lut_k2_a}, 0);
        chk({tag, "_lut_n"}, {lut_n1_a, lut_n2_a}, 0);
        chk({tag, "_coef"}, coef_a, 0);
        chk({tag, "_coef_valid"}, {coef_valid_a, coef_valid_b}, 0);
    endtask

    // issue one start and follow it to coef_valid, checking address walk and latency
    task automatic run_block(input string tag, input logic [2:0] k1v, input logic [2:0] k2v,
                             input int ea, input int eb);
        int t0, n, nexp, bad, first_n;
        exp_a.push_back(ea);
        exp_b.push_back(eb);
        @(posedge clk); #1;
        start = 1'b1; k1 = k1v; k2 = k2v;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0; k1 = ~k1v; k2 = ~k2v;
        chk({tag, "_busy"}, busy_a, 1);
        nexp = 0; bad = 0; first_n = -1; n = 0;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            n = cyc - t0;
            if (pix_re_a) begin
                if (pix_addr_a != 6'(nexp) || {lut_n1_a, lut_n2_a} != 6'(nexp)) bad++;
                if (nexp == 0) first_n = n;
                nexp++;
            end
            if (coef_valid_a) break;
        end
        chk({tag, "_first_addr_cycle"}, first_n, 1);
        chk({tag, "_addr_count"}, nexp, 64);
        chk({tag, "_addr_errs"}, bad, 0);
        chk({tag, "_valid_cycle"}, n, 68);
        chk({tag, "_lut_k"}, {lut_k1_a, lut_k2_a}, {k1v, k2v});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, n, naddr, bad, vcount;
        int v_cyc [2];
        rst_n = 1'b0; start = 1'b0; k1 = '0; k2 = '0; coef_ready = 1'b1;
        fill_const(0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // 1: flat 127 block, DC term; 8-bit instance saturates to 127
        fill_const(127, 256);
        run_block("s1", 3'd0, 3'd0, 1016, 127);
        @(posedge clk); #1;
        chk("s1_idle_busy", busy_a, 0);
        chk("s1_idle_valid", coef_valid_a, 0);
        chk("s1_idle_addr", pix_addr_a, 0);

        // 2: single pixel 100 at {3,4} against cos 48, other LUT entries irrelevant
        fill_const(0, -77);
        mem[28] = 8'sd100;
        lut_tab[28] = 48;
        run_block("s2", 3'd7, 3'd1, 5, 5);

        // 3: all -128 block: -1024 at 16 bits, saturates to -128 at 8 bits
        fill_const(-128, 256);
        run_block("s3", 3'd0, 3'd0, -1024, -128);

        // 4: consumer stalls 10 cycles; start pulses during the stall are ignored
        fill_const(127, 256);
        @(posedge clk); #1;
        coef_ready = 1'b0;
        run_block("s4", 3'd0, 3'd0, 1016, 127);
        for (int j = 0; j < 10; j++) begin
            @(posedge clk); #1;
            start = j[0]; k1 = 3'd3; k2 = 3'd4;
            chk("s4_hold_valid", coef_valid_a, 1);
            chk("s4_hold_coef", coef_a, 1016);
            chk("s4_hold_busy", busy_a, 1);
        end
        start = 1'b0;
        coef_ready = 1'b1;
        @(posedge clk); #1;
        chk("s4_release_busy", busy_a, 0);
        chk("s4_release_valid", coef_valid_a, 0);
        chk("s4_lut_k_kept", {lut_k1_a, lut_k2_a}, 6'b000_000);

        // 5: asynchronous reset at cycle 30 of RUN, then a clean rerun
        @(posedge clk); #1;
        start = 1'b1; k1 = 3'd2; k2 = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        chk("s5_addr_before_reset", pix_addr_a, 29);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("s5_abort");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_block("s5_rerun", 3'd0, 3'd0, 1016, 127);

        // 6: start held high with ready high: second block accepted at cycle 69
        @(posedge clk); #1;
        exp_a.push_back(1016); exp_a.push_back(1016);
        exp_b.push_back(127);  exp_b.push_back(127);
        start = 1'b1; k1 = 3'd0; k2 = 3'd0;
        t0 = cyc;
        naddr = 0; bad = 0; vcount = 0; v_cyc[0] = -1; v_cyc[1] = -1;
        for (int w = 0; w < 400 && vcount < 2; w++) begin
            @(negedge clk);
            n = cyc - t0;
            if (n == 69) chk("s6_gap_busy", busy_a, 0);
            if (n == 70) start = 1'b0;
            if (pix_re_a) begin
                if (pix_addr_a != 6'(naddr % 64)) bad++;
                if (naddr == 0 || naddr == 64) chk("s6_addr0_cycle", n, (naddr == 0) ? 1 : 70);
                naddr++;
            end
            if (coef_valid_a) begin
                v_cyc[vcount] = n;
                vcount++;
            end
        end
        start = 1'b0;
        chk("s6_addr_count", naddr, 128);
        chk("s6_addr_errs", bad, 0);
        chk("s6_valid_cycle0", v_cyc[0], 68);
        chk("s6_valid_cycle1", v_cyc[1], 137);

        repeat (5) @(posedge clk);
        #1;
        chk("final_busy", busy_a, 0);
        chk("sb_empty_a", exp_a.size(), 0);
        chk("sb_empty_b", exp_b.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
